// File: rtl/ddr3_bist_pkg.sv
// Shared definitions for the DDR3 user-port BIST: state encoding, beat size and data pattern.
package ddr3_bist_pkg;

    localparam int BEAT_BYTES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_WR_WAIT,
        S_RD_CMD,
        S_RD_DATA,
        S_RD_WAIT,
        S_DONE
    } bist_state_t;

    function automatic logic [127:0] bist_pattern(input logic [31:0] seed, input logic [31:0] k);
        logic [31:0] w;
        w = seed ^ k;
        return {~w, w, ~w, w};
    endfunction

endpackage

// File: rtl/ddr3_bist_pattern.sv
// Maps a global beat index to its 128-bit test pattern.
module ddr3_bist_pattern
    import ddr3_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic [31:0]  i_k,
    output logic [127:0] o_beat
);

    assign o_beat = bist_pattern(SEED, i_k);

endmodule

// File: rtl/ddr3_bist_ctrl.sv
// DDR3 user-port BIST: writes NUM_BURSTS bursts of a seeded pattern, reads them back and compares.
//   state     | meaning
//   S_IDLE    | waiting for start with calibration complete
//   S_WR_CMD  | write command pulse for burst b
//   S_WR_DATA | streaming write beats
//   S_WR_WAIT | waiting for write burst completion
//   S_RD_CMD  | read command pulse for burst b
//   S_RD_DATA | popping and comparing read beats
//   S_RD_WAIT | waiting for read burst completion
//   S_DONE    | one-cycle result publication
module ddr3_bist_ctrl
    import ddr3_bist_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter int                ADDR_W     = 30,
    parameter int                BURST_LEN  = 64,
    parameter int                NUM_BURSTS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       SEED       = 32'hA5A5_0000,
    parameter int                TMO_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              calib_ok,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              abort,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              u_wr_cmd_en,
    output logic              u_wr_en,
    output logic [DATA_W-1:0] u_wr_data,
    output logic [ADDR_W-1:0] u_wr_addr,
    output logic [6:0]        u_wr_len,
    input  logic              u_wr_rdy,
    input  logic              u_wr_cmd_done,
    output logic              u_rd_cmd_en,
    output logic              u_rd_en,
    output logic [ADDR_W-1:0] u_rd_addr,
    output logic [6:0]        u_rd_len,
    input  logic              u_rd_rdy,
    input  logic [DATA_W-1:0] u_rd_data,
    input  logic              u_rd_cmd_done
);

    localparam logic [6:0]        LEN_M1     = 7'(BURST_LEN - 1);
    localparam logic [31:0]       LAST_BURST = 32'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BURST_LEN * BEAT_BYTES);
    localparam int                BEAT_SHIFT = $clog2(BEAT_BYTES);

    bist_state_t       r_state;
    logic              r_busy, r_done, r_pass, r_timeout, r_abort;
    logic [15:0]       r_err_cnt;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_wr_cmd_en, r_wr_en, r_rd_cmd_en, r_rd_en;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [6:0]        r_wr_len, r_rd_len, r_beat;
    logic [31:0]       r_burst, r_k;
    logic              r_cmd_done_lat;
    logic [TMO_W-1:0]  r_tmo;

    logic [DATA_W-1:0] w_wr_beat, w_exp_beat;
    logic              w_wr_xfer, w_rd_xfer, w_progress, w_tmo_active, w_mismatch;
    logic [ADDR_W-1:0] w_k_addr;

    ddr3_bist_pattern #(.SEED(SEED)) u_wr_pat  (.i_k(r_k), .o_beat(w_wr_beat));
    ddr3_bist_pattern #(.SEED(SEED)) u_exp_pat (.i_k(r_k), .o_beat(w_exp_beat));

    assign w_wr_xfer    = r_wr_en & u_wr_rdy;
    assign w_rd_xfer    = r_rd_en & u_rd_rdy;
    assign w_progress   = w_wr_xfer | w_rd_xfer | r_wr_cmd_en | r_rd_cmd_en
                        | u_wr_cmd_done | u_rd_cmd_done;
    assign w_tmo_active = (r_state == S_WR_DATA) || (r_state == S_WR_WAIT)
                       || (r_state == S_RD_DATA) || (r_state == S_RD_WAIT);
    assign w_mismatch   = (u_rd_data != w_exp_beat);
    assign w_k_addr     = BASE_ADDR + (ADDR_W'(r_k) << BEAT_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_abort          <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_wr_cmd_en      <= 1'b0;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_wr_len         <= '0;
            r_rd_cmd_en      <= 1'b0;
            r_rd_en          <= 1'b0;
            r_rd_addr        <= '0;
            r_rd_len         <= '0;
            r_beat           <= '0;
            r_burst          <= '0;
            r_k              <= '0;
            r_cmd_done_lat   <= 1'b0;
            r_tmo            <= '0;
        end else begin
            r_wr_cmd_en <= 1'b0;
            r_rd_cmd_en <= 1'b0;

            // Stall watchdog: reload on any progress, count down only while waiting on the MCB.
            if (w_progress || !w_tmo_active)
                r_tmo <= '1;
            else if (r_tmo != '0)
                r_tmo <= r_tmo - 1'b1;

            if (r_busy && !calib_ok) begin
                r_state <= S_DONE;
                r_abort <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= 1'b0;
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
            end else if (w_tmo_active && !w_progress && r_tmo == '0) begin
                r_state   <= S_DONE;
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
                r_wr_en   <= 1'b0;
                r_rd_en   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && calib_ok) begin
                            r_state          <= S_WR_CMD;
                            r_busy           <= 1'b1;
                            r_done           <= 1'b0;
                            r_pass           <= 1'b0;
                            r_timeout        <= 1'b0;
                            r_abort          <= 1'b0;
                            r_err_cnt        <= '0;
                            r_first_err_addr <= '0;
                            r_wr_cmd_en      <= 1'b1;
                            r_wr_addr        <= BASE_ADDR;
                            r_wr_len         <= LEN_M1;
                            r_beat           <= '0;
                            r_burst          <= '0;
                            r_k              <= '0;
                            r_cmd_done_lat   <= 1'b0;
                        end
                    end
                    S_WR_CMD: begin
                        r_state <= S_WR_DATA;
                        r_wr_en <= 1'b1;
                    end
                    S_WR_DATA: begin
                        if (u_wr_cmd_done)
                            r_cmd_done_lat <= 1'b1;
                        if (w_wr_xfer) begin
                            r_k <= r_k + 32'd1;
                            if (r_beat == LEN_M1) begin
                                r_beat  <= '0;
                                r_wr_en <= 1'b0;
                                r_state <= S_WR_WAIT;
                            end else begin
                                r_beat <= r_beat + 7'd1;
                            end
                        end
                    end
                    S_WR_WAIT: begin
                        if (u_wr_cmd_done || r_cmd_done_lat) begin
                            r_cmd_done_lat <= 1'b0;
                            if (r_burst == LAST_BURST) begin
                                r_burst     <= '0;
                                r_k         <= '0;
                                r_rd_cmd_en <= 1'b1;
                                r_rd_addr   <= BASE_ADDR;
                                r_rd_len    <= LEN_M1;
                                r_state     <= S_RD_CMD;
                            end else begin
                                r_burst     <= r_burst + 32'd1;
                                r_wr_addr   <= r_wr_addr + STRIDE;
                                r_wr_cmd_en <= 1'b1;
                                r_state     <= S_WR_CMD;
                            end
                        end
                    end
                    S_RD_CMD: begin
                        r_state <= S_RD_DATA;
                        r_rd_en <= 1'b1;
                    end
                    S_RD_DATA: begin
                        if (u_rd_cmd_done)
                            r_cmd_done_lat <= 1'b1;
                        if (w_rd_xfer) begin
                            if (w_mismatch) begin
                                if (r_err_cnt != 16'hFFFF)
                                    r_err_cnt <= r_err_cnt + 16'd1;
                                if (r_err_cnt == '0)
                                    r_first_err_addr <= w_k_addr;
                            end
                            r_k <= r_k + 32'd1;
                            if (r_beat == LEN_M1) begin
                                r_beat  <= '0;
                                r_rd_en <= 1'b0;
                                r_state <= S_RD_WAIT;
                            end else begin
                                r_beat <= r_beat + 7'd1;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        if (u_rd_cmd_done || r_cmd_done_lat) begin
                            r_cmd_done_lat <= 1'b0;
                            if (r_burst == LAST_BURST) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= (r_err_cnt == '0);
                            end else begin
                                r_burst     <= r_burst + 32'd1;
                                r_rd_addr   <= r_rd_addr + STRIDE;
                                r_rd_cmd_en <= 1'b1;
                                r_state     <= S_RD_CMD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign abort          = r_abort;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign u_wr_cmd_en    = r_wr_cmd_en;
    assign u_wr_en        = r_wr_en;
    assign u_wr_data      = r_wr_en ? w_wr_beat : '0;
    assign u_wr_addr      = r_wr_addr;
    assign u_wr_len       = r_wr_len;
    assign u_rd_cmd_en    = r_rd_cmd_en;
    assign u_rd_en        = r_rd_en;
    assign u_rd_addr      = r_rd_addr;
    assign u_rd_len       = r_rd_len;

endmodule

// File: tb/tb_ddr3_bist_ctrl.sv
// Bench for ddr3_bist_ctrl: MCB model with a write/command scoreboard, table-driven runs plus abort/reset sequences.
module tb_ddr3_bist_ctrl;

    localparam logic [127:0] K5_BEAT = 128'hFFFF_FFFA_0000_0005_FFFF_FFFA_0000_0005;

    logic         clk, rst_n, calib_ok, start;
    logic         busy, done, pass, timeout, abort;
    logic [15:0]  err_cnt;
    logic [29:0]  first_err_addr;
    logic         u_wr_cmd_en, u_wr_en, u_wr_rdy, u_wr_cmd_done;
    logic [127:0] u_wr_data;
    logic [29:0]  u_wr_addr, u_rd_addr;
    logic [6:0]   u_wr_len, u_rd_len;
    logic         u_rd_cmd_en, u_rd_en, u_rd_rdy, u_rd_cmd_done;
    logic [127:0] u_rd_data;

    ddr3_bist_ctrl #(
        .DATA_W(128), .ADDR_W(30), .BURST_LEN(4), .NUM_BURSTS(2),
        .BASE_ADDR(30'd0), .SEED(32'h0), .TMO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calib_ok(calib_ok), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .abort(abort),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .u_wr_cmd_en(u_wr_cmd_en), .u_wr_en(u_wr_en), .u_wr_data(u_wr_data),
        .u_wr_addr(u_wr_addr), .u_wr_len(u_wr_len), .u_wr_rdy(u_wr_rdy),
        .u_wr_cmd_done(u_wr_cmd_done),
        .u_rd_cmd_en(u_rd_cmd_en), .u_rd_en(u_rd_en), .u_rd_addr(u_rd_addr),
        .u_rd_len(u_rd_len), .u_rd_rdy(u_rd_rdy), .u_rd_data(u_rd_data),
        .u_rd_cmd_done(u_rd_cmd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rdy_toggle;
        int flip_k;
        bit hold_rd_done;
        int exp_err;
        int exp_first;
        bit exp_pass;
        bit exp_tmo;
    } vec_t;

    vec_t vecs [4];

    int n_cmp = 0;
    int n_err = 0;

    // MCB model state
    logic [127:0] mem [16];
    logic [127:0] wr_q [$];
    logic [29:0]  wr_addr_q [$];
    logic [29:0]  rd_addr_q [$];
    bit rdy_toggle, hold_rd_done;
    int flip_k;
    int wr_ptr, wr_left, wr_cnt, rd_ptr, rd_left, rd_lat, rd_dly;
    int cyc, done_cyc, last_xfer;
    logic prev_done;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_beat(input int k);
        logic [31:0] w;
        w = 32'(k);
        return {~w, w, ~w, w};
    endfunction

    task automatic bfm_step();
        logic [127:0] d;
        logic [127:0] exp_d;
        logic [29:0]  exp_a;
        cyc++;
        if (done && !prev_done) done_cyc = cyc;
        prev_done     = done;
        u_wr_cmd_done = 1'b0;
        u_rd_cmd_done = 1'b0;
        u_rd_rdy      = 1'b0;
        u_rd_data     = '0;
        if (!busy) begin
            wr_left = 0; rd_left = 0; rd_lat = 0; rd_dly = 0; wr_cnt = 0;
            u_wr_rdy = 1'b0;
            return;
        end
        if (rd_dly > 0) begin
            rd_dly--;
            if (rd_dly == 0) u_rd_cmd_done = 1'b1;
        end
        if (u_wr_cmd_en) begin
            exp_a = (wr_addr_q.size() > 0) ? wr_addr_q.pop_front() : '1;
            chk("wr_addr", u_wr_addr, exp_a);
            chk("wr_len", u_wr_len, 128'd3);
            wr_ptr  = int'(u_wr_addr >> 4);
            wr_left = int'(u_wr_len) + 1;
        end
        u_wr_rdy = rdy_toggle ? ~u_wr_rdy : 1'b1;
        if (u_wr_en && u_wr_rdy) begin
            exp_d = (wr_q.size() > 0) ? wr_q.pop_front() : '0;
            chk("wr_data", u_wr_data, exp_d);
            if (wr_cnt == 5) chk("wr_beat_k5", u_wr_data, K5_BEAT);
            mem[wr_ptr & 15] = u_wr_data;
            wr_ptr++;
            wr_cnt++;
            last_xfer = cyc;
            if (wr_left > 0) begin
                wr_left--;
                // completion lands while the DUT is still in WR_DATA
                if (wr_left == 0) u_wr_cmd_done = 1'b1;
            end
        end
        if (u_rd_cmd_en) begin
            exp_a = (rd_addr_q.size() > 0) ? rd_addr_q.pop_front() : '1;
            chk("rd_addr", u_rd_addr, exp_a);
            chk("rd_len", u_rd_len, 128'd3);
            rd_ptr  = int'(u_rd_addr >> 4);
            rd_left = int'(u_rd_len) + 1;
            rd_lat  = 2;
        end
        if (rd_left > 0) begin
            if (rd_lat > 0) begin
                rd_lat--;
            end else begin
                d = mem[rd_ptr & 15];
                if (rd_ptr == flip_k) d[0] = ~d[0];
                u_rd_rdy  = 1'b1;
                u_rd_data = d;
                if (u_rd_en) begin
                    rd_ptr++;
                    rd_left--;
                    last_xfer = cyc;
                    if (rd_left == 0 && !hold_rd_done) rd_dly = 2;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bfm_step();
    endtask

    task automatic load_run(input vec_t v);
        rdy_toggle   = v.rdy_toggle;
        flip_k       = v.flip_k;
        hold_rd_done = v.hold_rd_done;
        wr_q.delete();
        wr_addr_q.delete();
        rd_addr_q.delete();
        for (int k = 0; k < 8; k++) wr_q.push_back(model_beat(k));
        for (int b = 0; b < 2; b++) begin
            wr_addr_q.push_back(30'(b * 64));
            rd_addr_q.push_back(30'(b * 64));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_status"}, {busy, done, pass, timeout, abort, err_cnt, first_err_addr}, '0);
        chk({tag, "_wr_ctl"}, {u_wr_cmd_en, u_wr_en, u_wr_addr, u_wr_len}, '0);
        chk({tag, "_wr_data"}, u_wr_data, '0);
        chk({tag, "_rd_ctl"}, {u_rd_cmd_en, u_rd_en, u_rd_addr, u_rd_len}, '0);
    endtask

    task automatic run_vec(input vec_t v);
        load_run(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) tick();
        chk("done", done, 128'd1);
        chk("busy_at_done", busy, 128'd0);
        chk("err_cnt", err_cnt, 128'(v.exp_err));
        chk("first_err_addr", first_err_addr, 128'(v.exp_first));
        chk("pass", pass, 128'(v.exp_pass));
        chk("timeout", timeout, 128'(v.exp_tmo));
        chk("abort", abort, 128'd0);
        chk("wr_beats_left", 128'(wr_q.size()), 128'd0);
        chk("wr_cmds_left", 128'(wr_addr_q.size()), 128'd0);
        chk("rd_cmds_left", 128'(rd_addr_q.size()), v.hold_rd_done ? 128'd1 : 128'd0);
        if (v.exp_tmo) chk("stall_cycles", 128'(done_cyc - last_xfer - 1), 128'd256);
        tick();
        tick();
        chk("done_held", done, 128'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, -1, 1'b0, 0, 0,  1'b1, 1'b0};
        vecs[1] = '{1'b0,  6, 1'b0, 1, 96, 1'b0, 1'b0};
        vecs[2] = '{1'b1, -1, 1'b0, 0, 0,  1'b1, 1'b0};
        vecs[3] = '{1'b0, -1, 1'b1, 0, 0,  1'b0, 1'b1};

        rst_n = 1'b0; calib_ok = 1'b1; start = 1'b0;
        u_wr_rdy = 1'b0; u_wr_cmd_done = 1'b0;
        u_rd_rdy = 1'b0; u_rd_data = '0; u_rd_cmd_done = 1'b0;
        rdy_toggle = 1'b0; hold_rd_done = 1'b0; flip_k = -1;
        cyc = 0; done_cyc = 0; last_xfer = 0; prev_done = 1'b0;
        wr_ptr = 0; wr_left = 0; wr_cnt = 0; rd_ptr = 0; rd_left = 0; rd_lat = 0; rd_dly = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        tick();
        tick();
        check_all_zero("por");
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // calib_ok lost mid-write, then a start without calibration must be ignored
        load_run(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !u_wr_en; i++) tick();
        chk("abort_reach_wr", u_wr_en, 128'd1);
        calib_ok = 1'b0;
        tick();
        chk("abort_flags", {done, abort, busy, pass, timeout, u_wr_en}, 128'b110000);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nocal_busy", busy, 128'd0);
            chk("nocal_cmd", u_wr_cmd_en, 128'd0);
        end
        chk("nocal_done_held", {done, abort}, 128'b11);
        calib_ok = 1'b1;
        tick();

        // asynchronous reset in the middle of the read phase
        load_run(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !u_rd_en; i++) tick();
        chk("rst_reach_rd", {u_rd_en, u_rd_len}, {1'b1, 7'd3});
        rst_n = 1'b0;
        #1;
        check_all_zero("midrd_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
